// File: rtl/sm4_key_expand_pkg.sv
// Shared SM4 key-schedule definitions: system constants, FSM encoding and
// the CK round-constant generator.
package sm4_key_expand_pkg;

   localparam int SM4_NR = 32;

   localparam logic [31:0] FK0 = 32'hA3B1BAC6;
   localparam logic [31:0] FK1 = 32'h56AA3350;
   localparam logic [31:0] FK2 = 32'h677D9197;
   localparam logic [31:0] FK3 = 32'hB27022DC;
   localparam logic [127:0] FK = {FK0, FK1, FK2, FK3};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } ks_state_e;

   // Byte j of CK[i] (j=0 is the MSB) is ((4i+j)*7) mod 256; 8-bit math wraps for us.
   function automatic logic [31:0] ck_word(input logic [4:0] idx);
      logic [31:0] w;
      logic [7:0]  b;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         b = (({3'b000, idx} * 8'd4) + 8'(j)) * 8'd7;
         w[31-8*j -: 8] = b;
      end
      return w;
   endfunction

endpackage

// File: rtl/s_box.sv
// SM4 8-bit substitution box, shared by the key schedule and round datapath.
module s_box (
   input  logic [7:0] in_i,
   output logic [7:0] out_o
);

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   assign out_o = SBOX[in_i];

endmodule

// File: rtl/sm4_key_round.sv
// One combinational SM4 key-schedule step: rk = K0 ^ T'(K1^K2^K3^CK) and the
// shifted {K1,K2,K3,rk} state for the next step.
module sm4_key_round
   import sm4_key_expand_pkg::*;
(
   input  logic [127:0] k_i,
   input  logic [31:0]  ck_i,
   output logic [127:0] k_next_o,
   output logic [31:0]  rk_o
);

   logic [31:0] k0, k1, k2, k3;
   logic [31:0] t_in;
   logic [31:0] t_sub;
   logic [31:0] t_lin;

   assign {k0, k1, k2, k3} = k_i;
   assign t_in = k1 ^ k2 ^ k3 ^ ck_i;

   // Byte lanes match the round datapath: lane 3 is bits [31:24].
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      s_box u_sbox (
         .in_i  (t_in[8*g +: 8]),
         .out_o (t_sub[8*g +: 8])
      );
   end

   // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
   assign t_lin = t_sub ^ {t_sub[18:0], t_sub[31:19]} ^ {t_sub[8:0], t_sub[31:9]};

   assign rk_o     = k0 ^ t_lin;
   assign k_next_o = {k1, k2, k3, rk_o};

endmodule

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: one round key per cycle into a 32x32 register
// file, read back in encrypt or reversed (decrypt) order.
module sm4_key_expand #(
   parameter int NR      = 32,
   parameter bit REG_OUT = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   input  logic [127:0] key_in,
   output logic         key_ready,
   output logic         keys_valid,
   output logic         busy,
   input  logic         dec_mode,
   input  logic [4:0]   rk_addr,
   output logic [31:0]  rk_out
);

   import sm4_key_expand_pkg::*;

   ks_state_e    state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [127:0] k_q, k_d;
   logic [31:0]  rk_q [NR];
   logic [31:0]  rk_d [NR];
   logic         keys_valid_q, keys_valid_d;
   logic         busy_q, busy_d;
   logic         key_ready_q, key_ready_d;

   logic [31:0]  ck;
   logic [127:0] round_k_next;
   logic [31:0]  round_rk;
   logic [4:0]   rd_addr;

   always_comb ck = ck_word(cnt_q);

   sm4_key_round u_round (
      .k_i      (k_q),
      .ck_i     (ck),
      .k_next_o (round_k_next),
      .rk_o     (round_rk)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      k_d          = k_q;
      rk_d         = rk_q;
      keys_valid_d = keys_valid_q;
      busy_d       = busy_q;
      key_ready_d  = key_ready_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (key_valid && key_ready_q) begin
               state_d      = ST_EXPAND;
               k_d          = key_in ^ FK;
               cnt_d        = 5'd0;
               keys_valid_d = 1'b0;
               busy_d       = 1'b1;
               key_ready_d  = 1'b0;
            end
         end
         ST_EXPAND: begin
            rk_d[cnt_q] = round_rk;
            k_d         = round_k_next;
            cnt_d       = cnt_q + 5'd1;
            // Last key written this cycle; cnt wraps to 0, unused until the next load.
            if (cnt_q == 5'd31) begin
               state_d      = ST_DONE;
               keys_valid_d = 1'b1;
               busy_d       = 1'b0;
               key_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            keys_valid_d = 1'b0;
            busy_d       = 1'b0;
            key_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 5'd0;
         k_q          <= '0;
         rk_q         <= '{default: '0};
         keys_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         key_ready_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         k_q          <= k_d;
         rk_q         <= rk_d;
         keys_valid_q <= keys_valid_d;
         busy_q       <= busy_d;
         key_ready_q  <= key_ready_d;
      end
   end

   assign key_ready  = key_ready_q;
   assign keys_valid = keys_valid_q;
   assign busy       = busy_q;

   // Decryption consumes the schedule back to front.
   always_comb rd_addr = dec_mode ? (5'd31 - rk_addr) : rk_addr;

   if (REG_OUT) begin : g_reg_out
      logic [31:0] rk_out_q, rk_out_d;
      always_comb rk_out_d = rk_q[rd_addr];
      always_ff @(posedge clk) begin
         if (!rst_n) rk_out_q <= '0;
         else        rk_out_q <= rk_out_d;
      end
      assign rk_out = rk_out_q;
   end else begin : g_comb_out
      assign rk_out = rk_q[rd_addr];
   end

endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: both read-latency variants driven in parallel and
// compared every cycle against a schedule model computed from MK directly.
module tb_sm4_key_expand;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic [127:0] key_in;
   logic         dec_mode;
   logic [4:0]   rk_addr;

   logic        ready0, kv0, busy0;
   logic [31:0] rko0;
   logic        ready1, kv1, busy1;
   logic [31:0] rko1;

   always #5 clk = ~clk;

   sm4_key_expand #(.NR(32), .REG_OUT(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
      .key_ready(ready0), .keys_valid(kv0), .busy(busy0),
      .dec_mode(dec_mode), .rk_addr(rk_addr), .rk_out(rko0)
   );

   sm4_key_expand #(.NR(32), .REG_OUT(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in),
      .key_ready(ready1), .keys_valid(kv1), .busy(busy1),
      .dec_mode(dec_mode), .rk_addr(rk_addr), .rk_out(rko1)
   );

   localparam logic [127:0] V1 = 128'h0123456789ABCDEFFEDCBA9876543210;

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [31:0] t_prime(input logic [31:0] x);
      logic [31:0] b;
      for (int j = 0; j < 4; j++) b[8*j +: 8] = SBOX[x[8*j +: 8]];
      return b ^ rotl(b, 13) ^ rotl(b, 23);
   endfunction

   function automatic logic [31:0] ck_ref(input int i);
      logic [31:0] w;
      for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      return w;
   endfunction

   // Round key idx of the schedule for master key mk, straight from the key-schedule recurrence.
   function automatic logic [31:0] ref_rk(input logic [127:0] mk, input int idx);
      logic [31:0] k [4];
      logic [31:0] nk;
      k[0] = mk[127:96] ^ 32'hA3B1BAC6;
      k[1] = mk[95:64]  ^ 32'h56AA3350;
      k[2] = mk[63:32]  ^ 32'h677D9197;
      k[3] = mk[31:0]   ^ 32'hB27022DC;
      nk = '0;
      for (int r = 0; r <= idx; r++) begin
         nk = k[0] ^ t_prime(k[1] ^ k[2] ^ k[3] ^ ck_ref(r));
         k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = nk;
      end
      return nk;
   endfunction

   function automatic int eff(input logic d, input logic [4:0] a);
      return d ? 31 - int'(a) : int'(a);
   endfunction

   // Model: the stored table, what is still to be written, and the delayed read.
   logic [31:0]  m_rk [32];
   logic [127:0] m_mk;
   int           m_cnt;
   bit           m_busy, m_valid;
   logic [31:0]  m_reg;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_rk[i] = '0;
         m_busy = 0; m_valid = 0; m_cnt = 0; m_reg = '0;
      end else begin
         m_reg = m_rk[eff(dec_mode, rk_addr)];
         if (m_busy) begin
            m_rk[m_cnt] = ref_rk(m_mk, m_cnt);
            m_cnt++;
            if (m_cnt == 32) begin m_busy = 0; m_valid = 1; end
         end else if (key_valid) begin
            m_mk = key_in; m_busy = 1; m_valid = 0; m_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("key_ready0", {31'b0, ready0}, {31'b0, !m_busy});
         check("busy0", {31'b0, busy0}, {31'b0, m_busy});
         check("keys_valid0", {31'b0, kv0}, {31'b0, m_valid});
         check("key_ready1", {31'b0, ready1}, {31'b0, !m_busy});
         check("busy1", {31'b0, busy1}, {31'b0, m_busy});
         check("keys_valid1", {31'b0, kv1}, {31'b0, m_valid});
         check("rk_out_comb", rko0, m_rk[eff(dec_mode, rk_addr)]);
         check("rk_out_reg", rko1, m_reg);
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic start_key(input logic [127:0] mk);
      key_in = mk; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_valid();
      int n = 0;
      while (kv0 !== 1'b1 && n < 64) begin step(); n++; end
      if (n >= 64) check("wait_keys_valid_timeout", {31'b0, kv0}, 32'd1);
   endtask

   task automatic load_and_time(input logic [127:0] mk);
      int cyc = 0;
      int bcnt = 0;
      key_in = mk; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      forever begin
         @(negedge clk);
         if (kv0 === 1'b1 || cyc >= 40) break;
         if (busy0 === 1'b1 && ready0 === 1'b0) bcnt++;
         @(posedge clk);
         cyc++;
      end
      step();
      check("accept_to_valid_cycles", 32'(cyc), 32'd32);
      check("busy_not_ready_cycles", 32'(bcnt), 32'd32);
   endtask

   task automatic read_at(input logic [4:0] a, input logic d, input logic [31:0] req, input string name);
      rk_addr = a; dec_mode = d;
      @(negedge clk);
      check({name, "_comb"}, rko0, req);
      step();
      @(negedge clk);
      check({name, "_reg"}, rko1, req);
      step();
   endtask

   task automatic sweep();
      for (int a = 0; a < 32; a++) begin
         for (int d = 0; d < 2; d++) begin
            rk_addr = 5'(a); dec_mode = 1'(d);
            step();
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; key_valid = 1'b0; key_in = '0; dec_mode = 1'b0; rk_addr = 5'd0;
      key_valid = 1'b1; key_in = V1;
      repeat (3) @(posedge clk);
      #2;
      key_valid = 1'b0;
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset state, including key_valid being ignored while in reset.
      @(negedge clk);
      check("rst_keys_valid", {31'b0, kv0}, 32'd0);
      check("rst_busy", {31'b0, busy0}, 32'd0);
      check("rst_key_ready", {31'b0, ready0}, 32'd1);
      check("rst_rk_out_reg", rko1, 32'd0);
      step();

      check("model_rk0", ref_rk(V1, 0), 32'hF12186F9);
      check("model_rk1", ref_rk(V1, 1), 32'h41662B61);
      check("model_rk31", ref_rk(V1, 31), 32'h9124A012);

      // Standard vector with accept-to-valid timing.
      load_and_time(V1);
      read_at(5'd0, 1'b0, 32'hF12186F9, "v1_rk0");
      read_at(5'd1, 1'b0, 32'h41662B61, "v1_rk1");
      read_at(5'd31, 1'b0, 32'h9124A012, "v1_rk31");
      read_at(5'd0, 1'b1, 32'h9124A012, "v1_dec0");
      read_at(5'd31, 1'b1, 32'hF12186F9, "v1_dec31");
      sweep();

      // A key offered during expansion is dropped.
      start_key(V1);
      repeat (5) step();
      key_in = '0; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      wait_valid();
      read_at(5'd0, 1'b0, 32'hF12186F9, "ignored_rk0");
      read_at(5'd31, 1'b0, 32'h9124A012, "ignored_rk31");

      // Reload from DONE.
      start_key(128'd0);
      @(negedge clk);
      check("reload_keys_valid_drop", {31'b0, kv0}, 32'd0);
      step();
      wait_valid();
      sweep();

      // Reset in the middle of expansion.
      start_key(V1);
      repeat (10) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_keys_valid", {31'b0, kv0}, 32'd0);
      check("midrst_busy", {31'b0, busy0}, 32'd0);
      check("midrst_rk_out_comb", rko0, 32'd0);
      check("midrst_rk_out_reg", rko1, 32'd0);
      step();
      load_and_time(V1);
      read_at(5'd0, 1'b0, 32'hF12186F9, "post_rst_rk0");
      read_at(5'd31, 1'b0, 32'h9124A012, "post_rst_rk31");

      // Random keys, random read addresses and stray key_valid pulses.
      for (int k = 0; k < 4; k++) begin
         start_key({$urandom, $urandom, $urandom, $urandom});
         for (int c = 0; c < 40; c++) begin
            rk_addr   = 5'($urandom);
            dec_mode  = 1'($urandom);
            key_valid = ($urandom_range(0, 7) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            step();
         end
         key_valid = 1'b0;
         wait_valid();
         for (int c = 0; c < 20; c++) begin
            rk_addr  = 5'($urandom);
            dec_mode = 1'($urandom);
            step();
         end
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
